// File: rtl/bit_serializer_if.sv
// Parallel-in handshake and serial-out stream of the bit serializer.
// The serializer uses the slave modport; the word producer uses master.
interface bit_serializer_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             dout;
   logic             dout_valid;
   logic             busy;
   logic             done;

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output dout,
      output dout_valid,
      output busy,
      output done
   );

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  dout,
      input  dout_valid,
      input  busy,
      input  done
   );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: each accepted word is sent one bit per DIV cycles.
// A new word may be accepted in the final cycle of the current one for a gapless stream.
module bit_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DIV       = 1,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_BIT  = 1'b0
) (
   input logic              clk,
   input logic              rst,
   bit_serializer_if.slave  bus
);
   localparam int unsigned BitW = $clog2(WIDTH);
   localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BitW-1:0] BitMax = BitW'(WIDTH - 1);
   localparam logic [DivW-1:0] DivMax = DivW'(DIV - 1);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DivW-1:0]  div_cnt_q, div_cnt_d;
   logic             dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             busy_q, busy_d;
   logic             ready;
   logic             done;
   logic             last;
   logic [WIDTH-1:0] shifted;

   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
   assign last    = (bit_cnt_q == BitMax) && (div_cnt_q == DivMax);

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      div_cnt_d    = div_cnt_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      busy_d       = busy_q;
      ready        = 1'b0;
      done         = 1'b0;

      unique case (state_q)
         StIdle: ready = 1'b1;
         StShift: begin
            ready = last;
            done  = last;
            if (last) begin
               state_d      = StIdle;
               bit_cnt_d    = '0;
               div_cnt_d    = '0;
               dout_d       = IDLE_BIT;
               dout_valid_d = 1'b0;
               busy_d       = 1'b0;
            end else if (div_cnt_q == DivMax) begin
               div_cnt_d = '0;
               bit_cnt_d = bit_cnt_q + BitW'(1);
               shreg_d   = shifted;
               dout_d    = first_bit(shifted);
            end else begin
               div_cnt_d = div_cnt_q + DivW'(1);
            end
         end
         default: ;
      endcase

      // A transfer overrides the idle/advance decisions above, in either state.
      if (ready && bus.in_valid) begin
         state_d      = StShift;
         shreg_d      = bus.in_data;
         bit_cnt_d    = '0;
         div_cnt_d    = '0;
         dout_d       = first_bit(bus.in_data);
         dout_valid_d = 1'b1;
         busy_d       = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         div_cnt_q    <= '0;
         dout_q       <= IDLE_BIT;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         div_cnt_q    <= div_cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.in_ready   = ready;
   assign bus.done       = done;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench: two serializer configurations checked every cycle against a bit scoreboard,
// plus a 1011 detector fed from the serial stream.
module tb_bit_serializer;
   logic clk = 1'b0;
   logic rst = 1'b0;

   bit_serializer_if #(.WIDTH(8)) b0 ();
   bit_serializer_if #(.WIDTH(8)) b1 ();

   bit_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
      .clk (clk),
      .rst (rst),
      .bus (b0)
   );

   bit_serializer #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
      .clk (clk),
      .rst (rst),
      .bus (b1)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit q0[$];
   bit q1[$];

   // Downstream overlapping 1011 detector on the DIV=1 stream; records bit index of each match.
   logic     det_clr = 1'b1;
   logic [2:0] det_win;
   int       det_idx;
   int       det_hits[$];

   always @(posedge clk) begin
      if (det_clr) begin
         det_win <= '0;
         det_idx <= 0;
      end else if (b0.dout_valid) begin
         det_win <= {det_win[1:0], b0.dout};
         det_idx <= det_idx + 1;
         if ({det_win, b0.dout} == 4'b1011) det_hits.push_back(det_idx);
      end
   end

   // Compares {dout_valid, dout, done, in_ready, busy} of both DUTs against the scoreboard.
   task automatic check_all(input string tag, output bit rdy0, output bit rdy1);
      logic [4:0] exp;
      logic [4:0] obs;
      bit b;
      if (q0.size() > 0) begin
         b = q0.pop_front();
         exp = {1'b1, b, q0.size() == 0, q0.size() == 0, 1'b1};
      end else begin
         exp = 5'b00010;
      end
      rdy0 = exp[1];
      obs = {b0.dout_valid, b0.dout, b0.done, b0.in_ready, b0.busy};
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s msb v/d/done/rdy/busy observed=%b expected=%b", tag, obs, exp);
      end
      if (q1.size() > 0) begin
         b = q1.pop_front();
         exp = {1'b1, b, q1.size() == 0, q1.size() == 0, 1'b1};
      end else begin
         exp = 5'b00010;
      end
      rdy1 = exp[1];
      obs = {b1.dout_valid, b1.dout, b1.done, b1.in_ready, b1.busy};
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s lsb_div3 v/d/done/rdy/busy observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1,
                       input string tag);
      bit rdy0, rdy1;
      @(negedge clk);
      check_all(tag, rdy0, rdy1);
      b0.in_valid = v0;
      b0.in_data  = d0;
      b1.in_valid = v1;
      b1.in_data  = d1;
      if (v0 && rdy0) for (int i = 7; i >= 0; i--) q0.push_back(d0[i]);
      if (v1 && rdy1) for (int i = 0; i < 8; i++) repeat (3) q1.push_back(d1[i]);
   endtask

   initial begin
      bit r0, r1;
      int exp_hits[3];
      int got;
      exp_hits = '{3, 10, 15};
      b0.in_valid = 1'b0;
      b0.in_data  = '0;
      b1.in_valid = 1'b0;
      b1.in_data  = '0;

      #1 rst = 1'b1;
      #1 check_all("reset_async", r0, r1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tick(0, 8'h00, 0, 8'h00, "post_reset_ready");

      // Basic MSB-first send of B5 while the LSB unit idles.
      tick(1, 8'hB5, 0, 8'h00, "basic_load");
      repeat (10) tick(0, 8'h5A, 0, 8'h00, "basic_bits");

      // LSB-first, DIV=3, word 01; in_data changes after capture must not matter.
      tick(0, 8'h00, 1, 8'h01, "div3_load");
      repeat (27) tick(0, 8'h00, 0, 8'hFE, "div3_bits");

      // Back-to-back with in_valid held high, 0B then F0.
      tick(1, 8'h0B, 0, 8'h00, "b2b_first");
      repeat (8) tick(1, 8'hF0, 0, 8'h00, "b2b_hold");
      repeat (10) tick(0, 8'h00, 0, 8'h00, "b2b_drain");

      // Backpressure: pulses while in_ready=0 are ignored on both units.
      tick(1, 8'hA3, 1, 8'hC6, "bp_load");
      repeat (2) tick(0, 8'h00, 0, 8'h00, "bp_bits");
      tick(1, 8'h5C, 1, 8'h39, "bp_pulse");
      repeat (27) tick(0, 8'h00, 0, 8'h00, "bp_drain");

      // Reset mid-word: FF on the MSB unit, rst raised between edges after bit 3.
      tick(1, 8'hFF, 1, 8'hFF, "rst_load");
      repeat (4) tick(0, 8'h00, 0, 8'h00, "rst_bits");
      #2 rst = 1'b1;
      #1 q0.delete();
      q1.delete();
      check_all("rst_mid_word", r0, r1);
      @(negedge clk);
      check_all("rst_held", r0, r1);
      rst = 1'b0;
      repeat (4) tick(0, 8'h00, 0, 8'h00, "rst_after");

      // End-to-end chain: B5 then 6B back-to-back into the 1011 detector.
      det_hits.delete();
      tick(0, 8'h00, 0, 8'h00, "chain_clr");
      det_clr = 1'b0;
      tick(1, 8'hB5, 0, 8'h00, "chain_first");
      repeat (8) tick(1, 8'h6B, 0, 8'h00, "chain_hold");
      repeat (10) tick(0, 8'h00, 0, 8'h00, "chain_drain");

      n_tests++;
      assert (det_hits.size() === 3) else begin
         n_fail++;
         $error("FAIL chain_match_count observed=%0d expected=3", det_hits.size());
      end
      for (int i = 0; i < 3; i++) begin
         got = (i < det_hits.size()) ? det_hits[i] : -1;
         n_tests++;
         assert (got === exp_hits[i]) else begin
            n_fail++;
            $error("FAIL chain_match_pos%0d observed=%0d expected=%0d", i, got, exp_hits[i]);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
